// File: rtl/dwt_pass_scheduler.sv
// dwt_pass_scheduler
// Sequences the 2D DWT lifting passes. Each decomposition level runs a row
// pass (mode 0) and then a column pass (mode 1) over the shrinking active
// region. For every even/odd pixel pair it issues one read request to the MAC
// pipeline. It counts the MAC write-backs that are still outstanding, so that
// a pass starts only after every result of the previous pass has been written.
// The ping-pong bank select toggles at each pass boundary.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         begin a transform (sampled only while idle)
//   busy, done    busy covers the whole transform; done is a 1-cycle pulse
//   rd_valid/rd_ready       read-pair request handshake
//   rd_mode, rd_line, rd_pix, rd_bank, level   request descriptor
//   wr_ack        one MAC result pair written back
//   err           sticky: wr_ack seen with nothing outstanding
module dwt_pass_scheduler #(
    parameter int HEIGHT              = 256,
    parameter int WIDTH               = 256,
    parameter int DECOMPOSITION_LEVEL = 1,
    localparam int PW = $clog2((HEIGHT > WIDTH) ? HEIGHT : WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_mode,
    output logic [PW-1:0] rd_line,
    output logic [PW-1:0] rd_pix,
    output logic          rd_bank,
    output logic [2:0]    level,
    input  logic          wr_ack,
    output logic          err
);

    localparam int DW = PW + 1;
    localparam int CW = $clog2(HEIGHT * WIDTH / 2) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          valid_r, valid_s;
    logic          mode_r, mode_s;
    logic          bank_r, bank_s;
    logic          err_r, err_s;
    logic [PW-1:0] line_r, line_s;
    logic [PW-1:0] pix_r, pix_s;
    logic [2:0]    level_r, level_s;
    logic [CW-1:0] cnt_r, cnt_s;

    logic [DW-1:0] w_l_s, h_l_s, pix_end_s, line_end_s;
    logic          accept_s, pix_last_s, line_last_s;

    assign accept_s = valid_r & rd_ready;

    // Active region of the current level and end-of-line / end-of-pass detection
    always_comb begin
        w_l_s       = DW'(WIDTH) >> level_r;
        h_l_s       = DW'(HEIGHT) >> level_r;
        // A row pass walks pixels along the width; a column pass swaps the axes
        pix_end_s   = mode_r ? h_l_s : w_l_s;
        line_end_s  = mode_r ? w_l_s : h_l_s;
        pix_last_s  = ({1'b0, pix_r} == (pix_end_s - DW'(2)));
        line_last_s = ({1'b0, line_r} == (line_end_s - DW'(1)));
    end

    // Outstanding write-back counter, error flag and pass-sequencing FSM
    always_comb begin
        state_s = state_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        valid_s = valid_r;
        mode_s  = mode_r;
        bank_s  = bank_r;
        err_s   = err_r;
        line_s  = line_r;
        pix_s   = pix_r;
        level_s = level_r;
        cnt_s   = cnt_r;

        // An accept and an ack in the same cycle cancel out
        case ({accept_s, wr_ack})
            2'b10: cnt_s = cnt_r + CW'(1);
            2'b01: begin
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_s = cnt_r - CW'(1);
                end else begin
                    cnt_s = cnt_r;
                    err_s = 1'b1;
                end
            end
            default: cnt_s = cnt_r;
        endcase

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_ISSUE;
                    busy_s  = 1'b1;
                    valid_s = 1'b1;
                    mode_s  = 1'b0;
                    bank_s  = 1'b0;
                    line_s  = {PW{1'b0}};
                    pix_s   = {PW{1'b0}};
                    level_s = 3'd0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (accept_s) begin
                    if (pix_last_s && line_last_s) begin
                        valid_s = 1'b0;
                        state_s = S_DRAIN;
                    end else if (pix_last_s) begin
                        pix_s  = {PW{1'b0}};
                        line_s = line_r + PW'(1);
                    end else begin
                        pix_s = pix_r + PW'(2);
                    end
                end else begin
                    state_s = S_ISSUE;
                end
            end
            S_DRAIN: begin
                // Looking at the next count lets the final ack move straight on to NEXT
                if (cnt_s == {CW{1'b0}}) begin
                    state_s = S_NEXT;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_NEXT: begin
                bank_s = ~bank_r;
                line_s = {PW{1'b0}};
                pix_s  = {PW{1'b0}};
                if (!mode_r) begin
                    mode_s  = 1'b1;
                    valid_s = 1'b1;
                    state_s = S_ISSUE;
                end else begin
                    mode_s  = 1'b0;
                    level_s = level_r + 3'd1;
                    if ((level_r + 3'd1) == 3'(DECOMPOSITION_LEVEL)) begin
                        state_s = S_DONE;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                    end else begin
                        valid_s = 1'b1;
                        state_s = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
            mode_r  <= 1'b0;
            bank_r  <= 1'b0;
            err_r   <= 1'b0;
            line_r  <= {PW{1'b0}};
            pix_r   <= {PW{1'b0}};
            level_r <= 3'd0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            valid_r <= valid_s;
            mode_r  <= mode_s;
            bank_r  <= bank_s;
            err_r   <= err_s;
            line_r  <= line_s;
            pix_r   <= pix_s;
            level_r <= level_s;
            cnt_r   <= cnt_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign rd_valid = valid_r;
    assign rd_mode  = mode_r;
    assign rd_line  = line_r;
    assign rd_pix   = pix_r;
    assign rd_bank  = bank_r;
    assign level    = level_r;
    assign err      = err_r;

endmodule

// File: tb/tb_dwt_pass_scheduler.sv
// Directed bench for dwt_pass_scheduler on an 8x8 image. Instance A runs one
// decomposition level and instance B runs two; sel chooses which instance the
// stimulus drives and the checks observe. Expected request order comes from
// nested loops over level/mode/line/pix. MAC acks are modelled 3 cycles after
// each accept.
module tb_dwt_pass_scheduler;

    localparam int H = 8;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, rd_ready, wr_ack;
    logic sel;

    logic       a_busy, a_done, a_valid, a_mode, a_bank, a_err;
    logic [2:0] a_line, a_pix, a_level;
    logic       b_busy, b_done, b_valid, b_mode, b_bank, b_err;
    logic [2:0] b_line, b_pix, b_level;

    logic       o_busy, o_done, o_valid, o_mode, o_bank, o_err;
    logic [2:0] o_line, o_pix, o_level;

    dwt_pass_scheduler #(.HEIGHT(H), .WIDTH(W), .DECOMPOSITION_LEVEL(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(sel ? 1'b0 : start),
        .busy(a_busy), .done(a_done), .rd_valid(a_valid),
        .rd_ready(sel ? 1'b0 : rd_ready), .rd_mode(a_mode), .rd_line(a_line),
        .rd_pix(a_pix), .rd_bank(a_bank), .level(a_level),
        .wr_ack(sel ? 1'b0 : wr_ack), .err(a_err)
    );

    dwt_pass_scheduler #(.HEIGHT(H), .WIDTH(W), .DECOMPOSITION_LEVEL(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(sel ? start : 1'b0),
        .busy(b_busy), .done(b_done), .rd_valid(b_valid),
        .rd_ready(sel ? rd_ready : 1'b0), .rd_mode(b_mode), .rd_line(b_line),
        .rd_pix(b_pix), .rd_bank(b_bank), .level(b_level),
        .wr_ack(sel ? wr_ack : 1'b0), .err(b_err)
    );

    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_done  = sel ? b_done  : a_done;
    assign o_valid = sel ? b_valid : a_valid;
    assign o_mode  = sel ? b_mode  : a_mode;
    assign o_line  = sel ? b_line  : a_line;
    assign o_pix   = sel ? b_pix   : a_pix;
    assign o_bank  = sel ? b_bank  : a_bank;
    assign o_level = sel ? b_level : a_level;
    assign o_err   = sel ? b_err   : a_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ack_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [10:0] pack_now();
        return {o_level, o_bank, o_mode, o_line, o_pix};
    endfunction

    // Full transform on the selected instance with scoreboard of every accepted request
    task automatic run_xform(input int nlev, input bit bp, input bit hold);
        logic [10:0] exp_q[$];
        logic [10:0] prev;
        int acc_n, ack_n, done_n, done_cyc, last_ack, first_col, hold_cnt, total;
        bit stalled, holding;
        for (int lv = 0; lv < nlev; lv++) begin
            for (int m = 0; m < 2; m++) begin
                int nl, np;
                nl = (m == 0) ? (H >> lv) : (W >> lv);
                np = (m == 0) ? (W >> lv) : (H >> lv);
                for (int ln = 0; ln < nl; ln++) begin
                    for (int px = 0; px < np; px += 2) begin
                        exp_q.push_back({3'(lv), 1'((2 * lv + m) & 1), 1'(m), 3'(ln), 3'(px)});
                    end
                end
            end
        end
        total = exp_q.size();
        ack_q.delete();
        acc_n = 0; ack_n = 0; done_n = 0; done_cyc = -1; last_ack = -1;
        first_col = -1; hold_cnt = 0; stalled = 1'b0; prev = '0;
        start = 1'b1; rd_ready = 1'b0; wr_ack = 1'b0;
        tick();
        start = 1'b0;
        check_val("start_busy", 32'(o_busy), 32'd1);
        check_val("start_valid", 32'(o_valid), 32'd1);
        for (int i = 0; i < 3000; i++) begin
            start = 1'b0;
            if (o_done) begin
                done_n++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check_val("done_busy_low", 32'(o_busy), 32'd0);
                    check_val("done_gap", 32'(cyc - last_ack), 32'd2);
                    start = 1'b1;
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 3) break;
            if (stalled) begin
                check_val("stall_hold", 32'(pack_now()), 32'(prev));
                check_val("stall_valid", 32'(o_valid), 32'd1);
            end
            if (o_valid && o_mode && first_col < 0) begin
                first_col = cyc;
                check_val("col_gap", 32'(cyc - last_ack), 32'd2);
            end
            if (acc_n == 10 && o_valid) start = 1'b1;
            rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_valid && rd_ready) begin
                if (exp_q.size() > 0) check_val("req", 32'(pack_now()), 32'(exp_q.pop_front()));
                else check_val("extra_req", 32'(acc_n + 1), 32'(total));
                acc_n++;
                ack_q.push_back(cyc + 3);
            end
            stalled = o_valid && !rd_ready;
            prev    = pack_now();
            holding = hold && (hold_cnt < 10);
            if (hold && acc_n >= 32 && hold_cnt < 10) begin
                hold_cnt++;
                if (hold_cnt == 10) begin
                    check_val("drain_valid", 32'(o_valid), 32'd0);
                    check_val("drain_mode", 32'(o_mode), 32'd0);
                end
            end
            wr_ack = 1'b0;
            if (!holding && ack_q.size() > 0 && ack_q[0] <= cyc) begin
                void'(ack_q.pop_front());
                wr_ack   = 1'b1;
                ack_n++;
                last_ack = cyc;
            end
            tick();
        end
        start = 1'b0; rd_ready = 1'b0; wr_ack = 1'b0;
        if (done_cyc < 0) check_val("timeout_done", 32'd0, 32'd1);
        check_val("accepts", 32'(acc_n), 32'(total));
        check_val("acks", 32'(ack_n), 32'(total));
        check_val("done_pulses", 32'(done_n), 32'd1);
        check_val("final_level", 32'(o_level), 32'(nlev));
        check_val("final_bank", 32'(o_bank), 32'd0);
        check_val("idle_busy", 32'(o_busy), 32'd0);
        check_val("no_err", 32'(o_err), 32'd0);
        check_val("exp_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int acc_n;
        bit reached;
        sel = 1'b0; rst = 1'b1; start = 1'b1; rd_ready = 1'b0; wr_ack = 1'b0;
        tick();
        tick();
        check_val("rst_desc", 32'(pack_now()), 32'd0);
        check_val("rst_valid", 32'(o_valid), 32'd0);
        check_val("rst_busy", 32'(o_busy), 32'd0);
        check_val("rst_done", 32'(o_done), 32'd0);
        check_val("rst_err", 32'(o_err), 32'd0);
        check_val("rst_busy_b", 32'(b_busy), 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        check_val("post_rst_busy", 32'(o_busy), 32'd0);

        run_xform(1, 1'b0, 1'b0);
        run_xform(1, 1'b1, 1'b0);
        run_xform(1, 1'b0, 1'b1);
        sel = 1'b1;
        run_xform(2, 1'b0, 1'b0);
        sel = 1'b0;

        // Ack with nothing outstanding sets the sticky error
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check_val("err_set", 32'(o_err), 32'd1);
        tick();
        check_val("err_sticky", 32'(o_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("err_clr", 32'(o_err), 32'd0);

        // Abort in the middle of the column pass
        ack_q.delete();
        acc_n = 0; reached = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (o_mode && acc_n >= 36) begin
                reached = 1'b1;
                break;
            end
            if (o_valid) begin
                acc_n++;
                ack_q.push_back(cyc + 3);
            end
            wr_ack = 1'b0;
            if (ack_q.size() > 0 && ack_q[0] <= cyc) begin
                void'(ack_q.pop_front());
                wr_ack = 1'b1;
            end
            tick();
        end
        check_val("abort_reach", 32'(reached), 32'd1);
        rst = 1'b1; rd_ready = 1'b0; wr_ack = 1'b0;
        tick();
        rst = 1'b0;
        check_val("abort_desc", 32'(pack_now()), 32'd0);
        check_val("abort_valid", 32'(o_valid), 32'd0);
        check_val("abort_busy", 32'(o_busy), 32'd0);
        tick();
        check_val("abort_idle", 32'(o_busy), 32'd0);
        run_xform(1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dwt_pass_scheduler.md
Name: dwt_pass_scheduler

Overview:
Sequencer for the 2D DWT lifting datapath. Steps through decomposition levels and, within each level, a row pass (mode 0) followed by a column pass (mode 1). Issues even/odd pixel-pair read requests to the MAC pipeline and tracks outstanding MAC write-backs so that a pass never starts before the previous pass has fully landed. Drives the ping-pong bank select for the two image memories and reports completion with a start/done handshake.

Parameters:
HEIGHT, 256, image rows; power of two, >= 2^(DECOMPOSITION_LEVEL+1)
WIDTH, 256, image columns; power of two, >= 2^(DECOMPOSITION_LEVEL+1)
DECOMPOSITION_LEVEL, 1, number of levels to run, 1..7

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin transform; sampled only in IDLE
busy  out  1  high from the cycle after an accepted start until done
done  out  1  single-cycle pulse when the final pass has drained
rd_valid  out  1  read-pair request valid
rd_ready  in  1  MAC accepts request
rd_mode  out  1  0 = row pass, 1 = column pass
rd_line  out  PW  row index (mode 0) or column index (mode 1); PW = $clog2(max(HEIGHT,WIDTH))
rd_pix  out  PW  even pixel index within line; pair is (rd_pix, rd_pix+1)
rd_bank  out  1  memory bank read this pass; write bank = ~rd_bank
level  out  3  current decomposition level
wr_ack  in  1  one MAC result pair written back
err  out  1  sticky: wr_ack received with zero outstanding

Behaviour:
- Reset: state IDLE; busy=0, done=0, rd_valid=0, rd_mode=0, rd_line=0, rd_pix=0, rd_bank=0, level=0, err=0; outstanding counter = 0. Reset mid-operation aborts immediately to these values. Acks arriving after reset are not counted.
- Active region at level L: W_L = WIDTH>>L, H_L = HEIGHT>>L.
  - Mode 0: rd_line 0..H_L-1; rd_pix 0,2,..,W_L-2.
  - Mode 1: rd_line 0..W_L-1; rd_pix 0,2,..,H_L-2.
  - Each pass has W_L*H_L/2 requests.
- FSM states:
  - IDLE: start=1 -> ISSUE next cycle. busy=1 and rd_valid=1 from that cycle; the first request is (mode 0, line 0, pix 0).
  - ISSUE: rd_valid=1. On rd_valid&rd_ready, rd_pix += 2; at pix end it wraps to 0 and rd_line += 1. On acceptance of the last request, rd_valid=0 next cycle -> DRAIN.
  - DRAIN: wait until outstanding == 0 -> NEXT.
  - NEXT (1 cycle): toggle rd_bank; reset rd_line and rd_pix to 0.
    - If mode 0: mode <= 1, -> ISSUE.
    - If mode 1: level += 1, mode <= 0; -> DONE when the new level == DECOMPOSITION_LEVEL, else -> ISSUE.
  - DONE: done=1 for one cycle; busy falls with it; -> IDLE. level keeps its final value until the next start, which clears it to 0.
- Handshake: while rd_valid=1 and rd_ready=0, rd_mode, rd_line, rd_pix, rd_bank and level hold stable. rd_valid never deasserts without acceptance except on rst.
- Outstanding counter, width $clog2(HEIGHT*WIDTH/2)+1:
  - increments on accepted request; decrements on wr_ack.
  - Accept and ack in the same cycle: net unchanged.
  - wr_ack with counter 0 and no same-cycle accept: ignored, err <= 1 (cleared only by rst).
- start while busy is ignored. start in the DONE cycle is ignored.
- Pass boundary: no request of pass n+1 is issued before the final ack of pass n. The minimum gap is final ack -> NEXT -> first ISSUE cycle = 2 cycles.

Test Plan:
- Reset: hold rst 2 cycles with start=1 -> all outputs at reset values; busy stays 0.
- 8x8, 1 level, rd_ready=1, ack 3 cycles after each accept:
  - requests go (0,0,0),(0,0,2),(0,0,4),(0,0,6),(0,1,0)...(0,7,6): 32 row requests.
  - then (1,0,0)...(1,7,6): 32 column requests, with rd_bank 0 then 1.
  - done pulses once, 2 cycles after the 64th ack; final rd_bank=0.
- Backpressure: rd_ready toggles pseudo-randomly on the 8x8 run -> outputs stable while stalled, no skipped or duplicated (line,pix), 64 acks total.
- 8x8, 2 levels:
  - level 1 requests use rd_pix <= 2 and rd_line <= 3, 8 per pass.
  - total accepts = 80; level=2 at done.
- Drain: withhold all acks after the 32nd row request -> rd_valid stays 0 and mode stays 0. Releasing 32 acks -> first column request 2 cycles after the last ack.
- Error/abort:
  - wr_ack in IDLE -> err=1.
  - start pulsed mid-pass -> no effect.
  - rst during a column pass -> IDLE; a subsequent start restarts at (0,0,0) with rd_bank=0.
